// File: rtl/bias_pp_pkg.sv
// Shared state type and sizing helper for the bias ping-pong buffer.
package bias_pp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } bias_pp_state_t;

  function automatic int ch_idx_w(input int num_ch);
    return $clog2(num_ch);
  endfunction

endpackage

// File: rtl/bias_bank_mem.sv
// One bank of per-channel bias words: synchronous write, combinational read,
// asynchronous clear on reset.
module bias_bank_mem
  import bias_pp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [ch_idx_w(NUM_CH)-1:0]   waddr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [ch_idx_w(NUM_CH)-1:0]   raddr,
  output logic [DATA_W-1:0]             rdata
);

  localparam int CW = ch_idx_w(NUM_CH);
  localparam logic [CW:0] CH_LIMIT = (CW+1)'(NUM_CH);

  logic [DATA_W-1:0] mem [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-power-of-two channel counts leave unused index codes; they read as 0.
  assign rdata = ({1'b0, raddr} < CH_LIMIT) ? mem[raddr] : '0;

endmodule

// File: rtl/bias_pingpong_buf.sv
// Double-buffered per-channel bias store: loader fills the shadow bank while the
// PE array reads the active bank. Optional output alignment via BIAS_PP_SHIFT_EN.
module bias_pingpong_buf
  import bias_pp_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OUT_W      = 16,
  parameter int NUM_CH     = 16,
  parameter int BIAS_SHIFT = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_start,
  input  logic                        bias_valid,
  input  logic [DATA_W-1:0]           bias_in,
  output logic                        bias_ready,
  output logic                        load_done,
  input  logic                        swap,
  input  logic                        rd_en,
  input  logic [ch_idx_w(NUM_CH)-1:0] rd_ch,
  output logic [OUT_W-1:0]            bias_out,
  output logic                        bias_out_valid,
  output logic                        active_valid
);

  localparam int CW = ch_idx_w(NUM_CH);
  localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);
  localparam logic [CW:0]   CH_LIMIT = (CW+1)'(NUM_CH);

`ifdef BIAS_PP_SHIFT_EN
  localparam int SHIFT_AMT = BIAS_SHIFT;
  if (OUT_W < DATA_W + BIAS_SHIFT) begin : g_width_check
    $error("bias_pingpong_buf: OUT_W must be >= DATA_W + BIAS_SHIFT");
  end
`else
  // Without the shift option the alignment parameter has no effect.
  localparam int SHIFT_AMT = 0 * BIAS_SHIFT;
`endif

  bias_pp_state_t state, next_state;
  logic [CW-1:0]  wr_ptr;
  logic           act_sel;
  logic           wr_fire, restart, do_swap;
  logic [DATA_W-1:0] rd_word0, rd_word1, act_word;
  logic signed [OUT_W-1:0] ext_word;

  // A restart in LOAD drops any beat presented in the same cycle; swap beats load_start in FULL.
  always_comb begin
    next_state = state;
    wr_fire    = 1'b0;
    restart    = 1'b0;
    do_swap    = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          next_state = LOAD;
          restart    = 1'b1;
        end
      end
      LOAD: begin
        if (load_start) begin
          restart = 1'b1;
        end else if (bias_valid) begin
          wr_fire = 1'b1;
          if (wr_ptr == LAST_CH) next_state = FULL;
        end
      end
      FULL: begin
        if (swap) begin
          do_swap    = 1'b1;
          next_state = IDLE;
        end else if (load_start) begin
          next_state = LOAD;
          restart    = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      act_sel      <= 1'b0;
      active_valid <= 1'b0;
      bias_ready   <= 1'b0;
      load_done    <= 1'b0;
    end else begin
      state      <= next_state;
      bias_ready <= (next_state == LOAD);
      load_done  <= (next_state == FULL);
      if (restart) begin
        wr_ptr <= '0;
      end else if (wr_fire) begin
        wr_ptr <= (wr_ptr == LAST_CH) ? '0 : wr_ptr + CW'(1);
      end
      if (do_swap) begin
        act_sel      <= ~act_sel;
        active_valid <= 1'b1;
      end
    end
  end

  // The shadow bank is always the one not selected by act_sel.
  bias_bank_mem #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) u_bank0 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_fire & act_sel),
    .waddr (wr_ptr),
    .wdata (bias_in),
    .raddr (rd_ch),
    .rdata (rd_word0)
  );

  bias_bank_mem #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) u_bank1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_fire & ~act_sel),
    .waddr (wr_ptr),
    .wdata (bias_in),
    .raddr (rd_ch),
    .rdata (rd_word1)
  );

  assign act_word = act_sel ? rd_word1 : rd_word0;
  assign ext_word = OUT_W'($signed(act_word)) <<< SHIFT_AMT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_out       <= '0;
      bias_out_valid <= 1'b0;
    end else begin
      bias_out_valid <= rd_en;
      if (rd_en) begin
        bias_out <= ({1'b0, rd_ch} < CH_LIMIT) ? ext_word : '0;
      end
    end
  end

endmodule

// File: tb/tb_bias_pingpong_buf.sv
// Scoreboard bench for bias_pingpong_buf: directed scenarios then random traffic,
// checked against a queue-based behavioural model.
module tb_bias_pingpong_buf;

  localparam int DATA_W     = 8;
  localparam int OUT_W      = 16;
  localparam int NUM_CH     = 5;
  localparam int BIAS_SHIFT = 4;
`ifdef BIAS_PP_SHIFT_EN
  localparam int SH = BIAS_SHIFT;
`else
  localparam int SH = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_start = 1'b0;
  logic        bias_valid = 1'b0;
  logic [7:0]  bias_in = '0;
  logic        swap = 1'b0;
  logic        rd_en = 1'b0;
  logic [2:0]  rd_ch = '0;
  logic        bias_ready, load_done, bias_out_valid, active_valid;
  logic [15:0] bias_out;

  bias_pingpong_buf #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH), .BIAS_SHIFT(BIAS_SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .bias_valid(bias_valid),
    .bias_in(bias_in), .bias_ready(bias_ready), .load_done(load_done), .swap(swap),
    .rd_en(rd_en), .rd_ch(rd_ch), .bias_out(bias_out), .bias_out_valid(bias_out_valid),
    .active_valid(active_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] out;
    logic        ready;
    logic        done;
    logic        av;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: two banks of plain ints, the in-progress load as a queue.
  int          bank[2][NUM_CH];
  int          shadow_q[$];
  bit          m_loading, m_full, m_act, m_av;
  logic [15:0] m_last;

  function automatic logic [15:0] ext(input int v);
    int s;
    s = v * (1 << SH);
    return s[15:0];
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NUM_CH; i++) bank[b][i] = 0;
    shadow_q.delete();
    m_loading = 0; m_full = 0; m_act = 0; m_av = 0;
    m_last = '0;
  endtask

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, req);
    end
  endtask

  task automatic apply_stimulus(input bit ls, input bit bv, input logic [7:0] bi,
                                input bit sw, input bit re, input logic [2:0] rc);
    exp_t e;
    int   v;
    int   nb;
    @(negedge clk);
    load_start = ls; bias_valid = bv; bias_in = bi; swap = sw; rd_en = re; rd_ch = rc;
    v = $signed(bi);
    e.valid = re;
    if (re) m_last = (int'(rc) < NUM_CH) ? ext(bank[m_act][rc]) : 16'h0;
    e.out = m_last;
    if (m_full) begin
      if (sw) begin
        nb = m_act ? 0 : 1;
        for (int i = 0; i < NUM_CH; i++) bank[nb][i] = shadow_q[i];
        m_act = ~m_act; m_av = 1; m_full = 0;
      end else if (ls) begin
        m_full = 0; m_loading = 1; shadow_q.delete();
      end
    end else if (m_loading) begin
      if (ls) shadow_q.delete();
      else if (bv) begin
        shadow_q.push_back(v);
        if (shadow_q.size() == NUM_CH) begin m_loading = 0; m_full = 1; end
      end
    end else if (ls) begin
      m_loading = 1; shadow_q.delete();
    end
    e.ready = m_loading; e.done = m_full; e.av = m_av;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycle();
    apply_stimulus(0, 0, 8'h00, 0, 0, 3'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    load_start = 0; bias_valid = 0; swap = 0; rd_en = 0;
    rst_n = 1'b0;
    #1;
    check_output("rst bias_out", bias_out, 16'h0);
    check_output("rst bias_out_valid", 16'(bias_out_valid), 16'h0);
    check_output("rst bias_ready", 16'(bias_ready), 16'h0);
    check_output("rst load_done", 16'(load_done), 16'h0);
    check_output("rst active_valid", 16'(active_valid), 16'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expectation per cycle, independent of the stimulus thread.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("bias_out_valid", 16'(bias_out_valid), 16'(e.valid));
        check_output("bias_out", bias_out, e.out);
        check_output("bias_ready", 16'(bias_ready), 16'(e.ready));
        check_output("load_done", 16'(load_done), 16'(e.done));
        check_output("active_valid", 16'(active_valid), 16'(e.av));
      end
    end
  end

  int v1[NUM_CH] = '{5, -3, 127, -128, 1};

  initial begin : stimulus
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check_output("por bias_out", bias_out, 16'h0);
    check_output("por active_valid", 16'(active_valid), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reads before any swap, including an out-of-range channel.
    apply_stimulus(0, 0, 8'h00, 0, 1, 3'd3);
    apply_stimulus(0, 0, 8'h00, 0, 1, 3'd5);
    idle_cycle();

    // Full load of signed extremes, swap, read back every channel.
    apply_stimulus(1, 0, 8'h00, 0, 0, 3'd0);
    for (int i = 0; i < NUM_CH; i++) apply_stimulus(0, 1, 8'(v1[i]), 0, 0, 3'd0);
    idle_cycle();
    apply_stimulus(0, 0, 8'h00, 1, 0, 3'd0);
    for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 8'h00, 0, 1, 3'(i));

    // Load 10..50 into the shadow bank while reading the active bank.
    apply_stimulus(1, 0, 8'h00, 0, 1, 3'd1);
    for (int i = 0; i < NUM_CH; i++) apply_stimulus(0, 1, 8'(10 * (i + 1)), 0, 1, 3'(i));
    apply_stimulus(0, 0, 8'h00, 1, 1, 3'd0);
    apply_stimulus(0, 0, 8'h00, 0, 1, 3'd0);
    apply_stimulus(0, 0, 8'h00, 0, 1, 3'd4);

    // Swap in IDLE and LOAD is ignored; restart mid-load drops the same-cycle beat.
    apply_stimulus(0, 0, 8'h00, 1, 1, 3'd2);
    apply_stimulus(1, 0, 8'h00, 0, 0, 3'd0);
    apply_stimulus(0, 1, 8'h07, 0, 0, 3'd0);
    apply_stimulus(0, 1, 8'h08, 1, 1, 3'd2);
    apply_stimulus(1, 1, 8'h09, 0, 0, 3'd0);
    for (int i = 0; i < NUM_CH; i++) apply_stimulus(0, 1, 8'(-20 - i), 0, 0, 3'd0);
    apply_stimulus(1, 0, 8'h00, 1, 0, 3'd0);
    for (int i = 0; i < NUM_CH; i++) apply_stimulus(0, 0, 8'h00, 0, 1, 3'(i));

    // load_start in FULL discards, then a fresh load completes.
    apply_stimulus(1, 0, 8'h00, 0, 0, 3'd0);
    for (int i = 0; i < NUM_CH; i++) apply_stimulus(0, 1, 8'(i + 60), 0, 0, 3'd0);
    apply_stimulus(1, 0, 8'h00, 0, 0, 3'd0);
    for (int i = 0; i < NUM_CH; i++) apply_stimulus(0, 1, 8'(i + 90), 0, 0, 3'd0);
    apply_stimulus(0, 0, 8'h00, 1, 0, 3'd0);
    for (int i = 0; i < NUM_CH; i++) apply_stimulus(0, 0, 8'h00, 0, 1, 3'(i));

    // Reset mid-load, then a load of zeros must read back all zeros.
    apply_stimulus(1, 0, 8'h00, 0, 0, 3'd0);
    apply_stimulus(0, 1, 8'h33, 0, 0, 3'd0);
    apply_stimulus(0, 1, 8'h44, 0, 0, 3'd0);
    reset_dut();
    apply_stimulus(1, 0, 8'h00, 0, 0, 3'd0);
    for (int i = 0; i < NUM_CH; i++) apply_stimulus(0, 1, 8'h00, 0, 0, 3'd0);
    apply_stimulus(0, 0, 8'h00, 1, 0, 3'd0);
    for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 8'h00, 0, 1, 3'(i));

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      apply_stimulus($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
                     8'($urandom), $urandom_range(0, 9) == 0,
                     $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
    end
    idle_cycle();

    @(posedge clk);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bias_pingpong_buf.md
# bias_pingpong_buf

Multi-channel, double-buffered bias store that replaces the single-register bias buffer in the convolution datapath. It holds one signed bias per output channel in two banks. The loader streams the next layer's biases into the shadow bank while the PE array reads the active bank by channel index. A swap command exchanges the two banks at a layer boundary. Read data is sign-extended to accumulator width.

## Interface
- `DATA_W`, 8: width of each signed incoming bias word.
- `OUT_W`, 16: width of the signed output; must be ≥ `DATA_W + BIAS_SHIFT`.
- `NUM_CH`, 16: biases per bank (output channels); ≥ 2.
- `BIAS_SHIFT`, 0: left-shift alignment amount. Used only when `BIAS_PP_SHIFT_EN` is defined.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_start` in 1: one-cycle pulse; begins or restarts loading the shadow bank.
- `bias_valid` in 1: `bias_in` carries a valid word.
- `bias_in` in `DATA_W`: signed bias word.
- `bias_ready` out 1: shadow bank accepts a word (high only in LOAD).
- `load_done` out 1: level; shadow bank is complete (high in FULL).
- `swap` in 1: one-cycle pulse; promotes the shadow bank to active.
- `rd_en` in 1: read request on the active bank.
- `rd_ch` in `$clog2(NUM_CH)`: channel index to read.
- `bias_out` out `OUT_W`: signed bias for the requested channel.
- `bias_out_valid` out 1: `bias_out` is valid this cycle.
- `active_valid` out 1: the active bank has been loaded at least once since reset.

## Operation
- State machine `IDLE`/`LOAD`/`FULL`; `wr_ptr` counts 0..`NUM_CH`-1; `act_sel` selects the active bank (0/1).
- IDLE:
  - `load_start` → LOAD, `wr_ptr`=0.
  - `swap` is ignored.
- LOAD:
  - `bias_ready`=1.
  - On `bias_valid & bias_ready`, write `shadow[wr_ptr]` and increment `wr_ptr`.
  - The beat written at `wr_ptr`=`NUM_CH`-1 → FULL.
  - `load_start` in LOAD restarts with `wr_ptr`=0; any beat in that same cycle is dropped.
  - `swap` is ignored.
- FULL:
  - `bias_ready`=0, `load_done`=1.
  - `swap` → toggle `act_sel`, set `active_valid`=1, → IDLE.
  - `load_start` without `swap` discards the shadow contents, → LOAD, `wr_ptr`=0.
  - `swap` and `load_start` in the same cycle: `swap` wins and `load_start` is ignored.
- Read:
  - `rd_en` with `rd_ch` < `NUM_CH` → `bias_out` = sign-extended `active[rd_ch]`.
  - `rd_ch` ≥ `NUM_CH` → `bias_out`=0 and `bias_out_valid`=1.
  - `rd_en`=0 → `bias_out` holds its last value; `bias_out_valid`=0.
- Reads are allowed in every state and never stall. Loading never disturbs the active bank.
- `rd_en` in the same cycle as an accepted `swap` reads the pre-swap active bank.
- Before the first swap, reads return 0; `active_valid` stays 0.

## Timing
- Reset values: all outputs 0, both banks 0, `act_sel`=0, `wr_ptr`=0, state IDLE.
- Reset asserted mid-load aborts the load and clears both banks.
- Read latency is 1 cycle: `bias_out` and `bias_out_valid` are registered from `rd_en`/`rd_ch` sampled at edge N and are valid after edge N.
- Load throughput is 1 word per cycle.
- `load_done` rises on the edge that writes the last word.
- `act_sel` toggles on the `swap` edge; a read issued in the following cycle sees the new bank.
- `bias_ready` is a registered function of state, so there is no combinational path from `bias_valid`.

## Configuration
- `BIAS_PP_SHIFT_EN` defined: `bias_out` = sign-extended bias << `BIAS_SHIFT`, with zero-filled LSBs. `OUT_W ≥ DATA_W + BIAS_SHIFT` is checked with an elaboration-time assertion.
- `BIAS_PP_SHIFT_EN` not defined: plain sign extension, and `BIAS_SHIFT` is ignored.

## Structure
- Package `bias_pp_pkg` holds:
  - the `bias_pp_state_t` enum (IDLE, LOAD, FULL);
  - function `ch_idx_w(NUM_CH)` returning `$clog2(NUM_CH)`.
- Sub-module `bias_bank_mem`: one register bank of `NUM_CH`×`DATA_W` with a synchronous write port, a combinational read port and asynchronous clear. It is instantiated twice. The top level holds the FSM, pointer, bank select and output register.

## Test plan
- Reset, then `rd_en` with `rd_ch`=3 → `bias_out`=0, `bias_out_valid`=1 one cycle later, `active_valid`=0.
- `NUM_CH`=4: `load_start`, then stream 5, -3, 127, -128 on consecutive cycles → `load_done`=1 after the 4th beat. Then `swap`, then read ch 0..3 → 5, -3, 127, -128 sign-extended (-128 → 0xFF80 at `OUT_W`=16).
- While bank A is active with data 1..4, load 10..40 into the shadow bank. Reads issued mid-load return 1..4. A read issued in the same cycle as `swap` returns the old value; the next cycle returns the new one.
- `load_start` after 2 beats, then 4 new beats → only the new values appear after swap. `swap` pulsed in IDLE or LOAD → `act_sel` unchanged.
- Assert `rst_n` low mid-load after 2 beats → all outputs 0 and both banks read 0 after the next load and swap of zeros. `rd_ch`=5 with `NUM_CH`=4 → `bias_out`=0.
- With `BIAS_PP_SHIFT_EN` and `BIAS_SHIFT`=4: bias -3 → `bias_out`=0xFFD0.
